// File: rtl/counter_seq_checker.sv
// ---------------------------------------------------------------------------
// counter_seq_checker
//
// Receive-side monitor for a counter value stream. Each valid sample is
// compared against the value predicted from the previous sample through a
// successor table. The checker locks after LOCK_COUNT correct transitions in
// a row. While locked, every wrong transition raises a one-cycle error pulse
// and bumps a saturating error counter. UNLOCK_COUNT consecutive wrong
// transitions drop the checker back to acquisition.
//
// Optional build macro: BIDIR_CHECK_EN
//   When defined, a predecessor table is added and the stream may count down.
//   The first matching transition in ACQUIRE latches the direction. The
//   latched direction is reported on o_dir (1 = down).
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   i_sample_valid in   sample qualifier, one sample per cycle while high
//   i_sample       in   observed counter value [WIDTH]
//   i_err_clr      in   synchronous clear of o_err_count (wins over increment)
//   o_locked       out  high while in LOCKED
//   o_error_pulse  out  one-cycle flag for a wrong transition while LOCKED
//   o_err_count    out  saturating count of wrong transitions while LOCKED
//   o_expected     out  predicted next sample (0 in IDLE)
//   o_state        out  00 IDLE, 01 ACQUIRE, 10 LOCKED
//   o_dir          out  latched direction, only with BIDIR_CHECK_EN
// ---------------------------------------------------------------------------
module counter_seq_checker #(
    parameter int WIDTH        = 2,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sample_valid,
    input  logic [WIDTH-1:0]     i_sample,
    input  logic                 i_err_clr,
    output logic                 o_locked,
    output logic                 o_error_pulse,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [WIDTH-1:0]     o_expected,
`ifdef BIDIR_CHECK_EN
    output logic                 o_dir,
`endif
    output logic [1:0]           o_state
);

    localparam int DEPTH  = 2 ** WIDTH;
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [WIDTH-1:0]       r_last, w_last_nxt;
    logic [RUN_W-1:0]       r_run, w_run_nxt;
    logic [MISS_W-1:0]      r_miss, w_miss_nxt;
    logic [ERR_CNT_W-1:0]   r_err_count, w_err_count_nxt;
    logic                   r_error_pulse, w_error_pulse_nxt;
    logic [WIDTH-1:0]       r_expected, w_expected_nxt;
    logic                   r_locked;

    logic                   w_up_hit;
    logic                   w_dir_match;
    logic                   w_any_match;
    logic                   w_acq_match;

    // Saturating increment of the error counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    // Constant lookup tables; wrap from DEPTH-1 to 0 is part of the table.
    logic [WIDTH-1:0] w_succ_tbl [DEPTH];
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_succ
        assign w_succ_tbl[gi] = WIDTH'((gi + 1) % DEPTH);
    end

    assign w_up_hit = (i_sample == w_succ_tbl[r_last]);

`ifdef BIDIR_CHECK_EN
    logic [WIDTH-1:0] w_pred_tbl [DEPTH];
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_pred
        assign w_pred_tbl[gj] = WIDTH'((gj + DEPTH - 1) % DEPTH);
    end

    logic r_dir, w_dir_nxt;
    logic w_dn_hit;
    assign w_dn_hit    = (i_sample == w_pred_tbl[r_last]);
    assign w_dir_match = r_dir ? w_dn_hit : w_up_hit;
    assign w_any_match = w_up_hit | w_dn_hit;
    assign o_dir       = r_dir;
`else
    assign w_dir_match = w_up_hit;
    assign w_any_match = w_up_hit;
`endif

    // A run count of zero means direction latching is armed.
    assign w_acq_match = (r_run == '0) ? w_any_match : w_dir_match;

    always_comb begin
        w_state_nxt       = r_state;
        w_last_nxt        = r_last;
        w_run_nxt         = r_run;
        w_miss_nxt        = r_miss;
        w_err_count_nxt   = r_err_count;
        w_error_pulse_nxt = 1'b0;
`ifdef BIDIR_CHECK_EN
        w_dir_nxt         = r_dir;
`endif
        if (i_sample_valid) begin
            // Resync: the new sample always becomes the reference.
            w_last_nxt = i_sample;
            case (r_state)
                IDLE: begin
                    w_run_nxt   = '0;
                    w_state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (w_acq_match) begin
                        w_run_nxt = r_run + RUN_W'(1);
`ifdef BIDIR_CHECK_EN
                        if (r_run == '0) w_dir_nxt = ~w_up_hit;
`endif
                        if (r_run == RUN_W'(LOCK_COUNT - 1)) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (w_dir_match) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_error_pulse_nxt = 1'b1;
                        w_err_count_nxt   = sat_inc(r_err_count);
                        w_miss_nxt        = r_miss + MISS_W'(1);
                        if (r_miss == MISS_W'(UNLOCK_COUNT - 1)) begin
                            w_state_nxt = ACQUIRE;
                            w_run_nxt   = '0;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
        if (i_err_clr) w_err_count_nxt = '0;

        if (w_state_nxt == IDLE) begin
            w_expected_nxt = '0;
        end else begin
`ifdef BIDIR_CHECK_EN
            w_expected_nxt = w_dir_nxt ? w_pred_tbl[w_last_nxt] : w_succ_tbl[w_last_nxt];
`else
            w_expected_nxt = w_succ_tbl[w_last_nxt];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last        <= '0;
            r_run         <= '0;
            r_miss        <= '0;
            r_err_count   <= '0;
            r_error_pulse <= 1'b0;
            r_expected    <= '0;
            r_locked      <= 1'b0;
`ifdef BIDIR_CHECK_EN
            r_dir         <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_last        <= w_last_nxt;
            r_run         <= w_run_nxt;
            r_miss        <= w_miss_nxt;
            r_err_count   <= w_err_count_nxt;
            r_error_pulse <= w_error_pulse_nxt;
            r_expected    <= w_expected_nxt;
            r_locked      <= (w_state_nxt == LOCKED);
`ifdef BIDIR_CHECK_EN
            r_dir         <= w_dir_nxt;
`endif
        end
    end

    assign o_state       = r_state;
    assign o_locked      = r_locked;
    assign o_error_pulse = r_error_pulse;
    assign o_err_count   = r_err_count;
    assign o_expected    = r_expected;

endmodule

// File: tb/tb_counter_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_checker
//
// Scoreboard bench for counter_seq_checker (WIDTH=2, LOCK_COUNT=4,
// UNLOCK_COUNT=2, ERR_CNT_W=2). Each directed vector carries its
// hand-computed response, which is queued when the vector is driven and
// compared by the monitor after the following rising edge.
// ---------------------------------------------------------------------------
module tb_counter_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [1:0] sample = 2'd0;
    logic       err_clr = 1'b0;
    logic       locked;
    logic       error_pulse;
    logic [1:0] err_count;
    logic [1:0] expected;
    logic [1:0] state;

    counter_seq_checker #(
        .WIDTH(2), .LOCK_COUNT(4), .UNLOCK_COUNT(2), .ERR_CNT_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_sample_valid(sample_valid),
        .i_sample(sample),
        .i_err_clr(err_clr),
        .o_locked(locked),
        .o_error_pulse(error_pulse),
        .o_err_count(err_count),
        .o_expected(expected),
        .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [1:0] st;
        logic       pulse;
        logic [1:0] err;
        logic [1:0] exp;
    } resp_t;

    resp_t q[$];
    int n_vec = 0;
    int n_bad = 0;
    int vid = 0;

    // Monitor: compares the response to the vector sampled at this edge.
    always @(posedge clk) begin
        #1;
        if (!reset && q.size() > 0) begin
            resp_t r;
            logic  want_lock;
            r = q.pop_front();
            want_lock = (r.st == 2'b10);
            n_vec++;
            if (state !== r.st || locked !== want_lock || error_pulse !== r.pulse ||
                err_count !== r.err || expected !== r.exp) begin
                n_bad++;
                $display("FAIL vec%0d: got state=%b locked=%b pulse=%b err=%0d exp=%0d, want state=%b locked=%b pulse=%b err=%0d exp=%0d",
                         r.id, state, locked, error_pulse, err_count, expected,
                         r.st, want_lock, r.pulse, r.err, r.exp);
            end
        end
    end

    task automatic vec(input logic v, input logic [1:0] s, input logic c,
                       input logic [1:0] e_st, input logic e_p,
                       input logic [1:0] e_err, input logic [1:0] e_exp);
        resp_t r;
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        err_clr      = c;
        r.id = vid; r.st = e_st; r.pulse = e_p; r.err = e_err; r.exp = e_exp;
        vid++;
        q.push_back(r);
    endtask

    task automatic drain();
        @(negedge clk);
        sample_valid = 1'b0;
        err_clr      = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic chk_reset(input string tag);
        n_vec++;
        if (state !== 2'b00 || locked !== 1'b0 || error_pulse !== 1'b0 ||
            err_count !== 2'd0 || expected !== 2'd0) begin
            n_bad++;
            $display("FAIL %s: got state=%b locked=%b pulse=%b err=%0d exp=%0d, want all zero",
                     tag, state, locked, error_pulse, err_count, expected);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1 chk_reset("reset_hold");
        @(negedge clk);
        reset = 1'b0;

        // Acquire: 0,1,2,3,0 -> locked on fifth sample.
        vec(1, 0, 0, 2'b01, 0, 0, 1);
        vec(1, 1, 0, 2'b01, 0, 0, 2);
        vec(1, 2, 0, 2'b01, 0, 0, 3);
        vec(1, 3, 0, 2'b01, 0, 0, 0);
        vec(1, 0, 0, 2'b10, 0, 0, 1);
        // Locked at last=0: 1,3,0 -> one error, wrap accepted.
        vec(1, 1, 0, 2'b10, 0, 0, 2);
        vec(1, 3, 0, 2'b10, 1, 1, 0);
        vec(1, 0, 0, 2'b10, 0, 1, 1);
        // Move to last=1, then 3,1 -> two errors, unlock; 2,3,0,1 -> relock.
        vec(1, 1, 0, 2'b10, 0, 1, 2);
        vec(1, 3, 0, 2'b10, 1, 2, 0);
        vec(1, 1, 0, 2'b01, 1, 3, 2);
        vec(1, 2, 0, 2'b01, 0, 3, 3);
        vec(1, 3, 0, 2'b01, 0, 3, 0);
        vec(1, 0, 0, 2'b01, 0, 3, 1);
        vec(1, 1, 0, 2'b10, 0, 3, 2);
        // Clear on an idle cycle, then five isolated errors saturate at 3.
        vec(0, 2, 1, 2'b10, 0, 0, 2);
        vec(1, 3, 0, 2'b10, 1, 1, 0);
        vec(1, 0, 0, 2'b10, 0, 1, 1);
        vec(1, 2, 0, 2'b10, 1, 2, 3);
        vec(1, 3, 0, 2'b10, 0, 2, 0);
        vec(1, 1, 0, 2'b10, 1, 3, 2);
        vec(1, 2, 0, 2'b10, 0, 3, 3);
        vec(1, 0, 0, 2'b10, 1, 3, 1);
        vec(1, 1, 0, 2'b10, 0, 3, 2);
        vec(1, 3, 0, 2'b10, 1, 3, 0);
        vec(1, 0, 0, 2'b10, 0, 3, 1);
        // Sixth error with err_clr: clear wins, pulse still fires.
        vec(1, 2, 1, 2'b10, 1, 0, 3);
        vec(1, 3, 0, 2'b10, 0, 0, 0);
        // Valid gaps: outputs hold, gap samples ignored, pulse one cycle wide.
        vec(1, 0, 0, 2'b10, 0, 0, 1);
        vec(0, 2, 0, 2'b10, 0, 0, 1);
        vec(0, 2, 0, 2'b10, 0, 0, 1);
        vec(1, 1, 0, 2'b10, 0, 0, 2);
        vec(0, 0, 0, 2'b10, 0, 0, 2);
        vec(1, 3, 0, 2'b10, 1, 1, 0);
        vec(0, 2, 0, 2'b10, 0, 1, 0);
        vec(0, 2, 0, 2'b10, 0, 1, 0);
        vec(1, 0, 0, 2'b10, 0, 1, 1);
        vec(1, 1, 0, 2'b10, 0, 1, 2);
        drain();

        // Asynchronous reset between edges while LOCKED.
        #2 reset = 1'b1;
        #1 chk_reset("reset_async");
        @(negedge clk);
        reset = 1'b0;
        vec(1, 2, 0, 2'b01, 0, 0, 3);
        vec(1, 3, 0, 2'b01, 0, 0, 0);
        vec(1, 0, 0, 2'b01, 0, 0, 1);
        vec(1, 1, 0, 2'b01, 0, 0, 2);
        vec(1, 2, 0, 2'b10, 0, 0, 3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
